// File: rtl/proc_control.sv
// proc_control: multi-cycle sequencer driving ALU op code and bus/register enables of the 16-bit datapath.
// Optional macro PROC_CTRL_ILLEGAL_FLAG_EN adds Illegal and IllegalSticky outputs.
module proc_control #(
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [15:0]      DIN,
  output logic             IRin,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic             DINout,
  output logic             Gout,
  output logic             Ain,
  output logic             Gin,
  output logic [2:0]       Control,
  output logic             Done
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
  ,
  output logic             Illegal,
  output logic             IllegalSticky
`endif
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0] op;
  logic [NREGS-1:0] rx_oh, ry_oh;
  logic alu_op, ill_op, ir_unused;
  assign op = ir_q[15:12];
  assign rx_oh = NREGS'(1) << ir_q[11:9];
  assign ry_oh = NREGS'(1) << ir_q[8:6];
  assign alu_op = !op[3] && (op[3:1] != 3'b000);
  assign ill_op = op[3];
  assign ir_unused = ^ir_q[5:0];
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    IRin = 1'b0;
    Rout = '0;
    Rin = '0;
    DINout = 1'b0;
    Gout = 1'b0;
    Ain = 1'b0;
    Gin = 1'b0;
    Control = 3'b000;
    Done = 1'b0;
    case (state_q)
      T0: begin
        IRin = Run;
        state_d = Run ? T1 : T0;
        ir_d = Run ? DIN : ir_q;
      end
      T1: begin
        state_d = alu_op ? T2 : T0;
        Done = !alu_op;
        Rout = (op == 4'd0) ? ry_oh : alu_op ? rx_oh : '0;
        Rin = (op[3:1] == 3'b000) ? rx_oh : '0;
        DINout = (op == 4'd1);
        Ain = alu_op;
      end
      T2: begin
        state_d = T3;
        Rout = ry_oh;
        Gin = 1'b1;
        Control = 3'(op - 4'd2);
      end
      default: begin
        state_d = T0;
        Gout = 1'b1;
        Rin = rx_oh;
        Done = 1'b1;
      end
    endcase
    // outputs are held inactive for the whole reset window, not just after the edge
    if (!Resetn) begin
      IRin = 1'b0;
      Rout = '0;
      Rin = '0;
      DINout = 1'b0;
      Gout = 1'b0;
      Ain = 1'b0;
      Gin = 1'b0;
      Control = 3'b000;
      Done = 1'b0;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
  logic sticky_q;
  assign Illegal = Resetn && (state_q == T1) && ill_op;
  assign IllegalSticky = Resetn && sticky_q;
  always_ff @(posedge Clock) sticky_q <= Resetn && (sticky_q || Illegal);
`else
  logic ill_unused;
  assign ill_unused = ill_op;
`endif
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: scoreboard bench; driver queues expected per-cycle outputs, monitor compares on the falling edge.
module tb_proc_control;
  typedef struct packed {
    logic       irin;
    logic [7:0] rout;
    logic [7:0] rin;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [2:0] ctl;
    logic       done;
    logic       ill;
    logic       stk;
  } vec_t;
  logic clk = 1'b1;
  logic resetn, run;
  logic [15:0] din;
  logic irin, dinout, gout, ain, gin, done, ill, stk;
  logic [7:0] rout, rin;
  logic [2:0] ctl;
  vec_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int failures = 0;
  logic exp_stk = 1'b0;
  always #5 clk = ~clk;
  proc_control #(.NREGS(8)) dut (
    .Clock(clk), .Resetn(resetn), .Run(run), .DIN(din),
    .IRin(irin), .Rout(rout), .Rin(rin), .DINout(dinout), .Gout(gout),
    .Ain(ain), .Gin(gin), .Control(ctl), .Done(done)
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
    , .Illegal(ill), .IllegalSticky(stk)
`endif
  );
`ifndef PROC_CTRL_ILLEGAL_FLAG_EN
  assign ill = 1'b0;
  assign stk = 1'b0;
`endif
  function automatic vec_t v(logic i, logic [7:0] ro, logic [7:0] ri, logic dn, logic go, logic a,
                             logic g, logic [2:0] c, logic d, logic il);
    vec_t e;
    e = '{irin: i, rout: ro, rin: ri, dinout: dn, gout: go, ain: a, gin: g, ctl: c, done: d, ill: il, stk: 1'b0};
    return e;
  endfunction
  task automatic cyc(input string nm, input logic rn, input logic r, input logic [15:0] d, input vec_t e);
    resetn = rn;
    run = r;
    din = d;
    e.stk = exp_stk && rn;
`ifndef PROC_CTRL_ILLEGAL_FLAG_EN
    e.ill = 1'b0;
    e.stk = 1'b0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (!rn) exp_stk = 1'b0;
    if (rn && e.ill) exp_stk = 1'b1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e, a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{irin: irin, rout: rout, rin: rin, dinout: dinout, gout: gout, ain: ain, gin: gin, ctl: ctl,
            done: done, ill: ill, stk: stk};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got irin=%b rout=%b rin=%b dinout=%b gout=%b ain=%b gin=%b ctl=%b done=%b ill=%b stk=%b, expected irin=%b rout=%b rin=%b dinout=%b gout=%b ain=%b gin=%b ctl=%b done=%b ill=%b stk=%b",
                 nm, a.irin, a.rout, a.rin, a.dinout, a.gout, a.ain, a.gin, a.ctl, a.done, a.ill, a.stk,
                 e.irin, e.rout, e.rin, e.dinout, e.gout, e.ain, e.gin, e.ctl, e.done, e.ill, e.stk);
      end
    end
  end
  localparam vec_t Z = '0;
  initial begin
    cyc("rst0", 1'b0, 1'b1, 16'hFFFF, Z);
    cyc("rst1", 1'b0, 1'b1, 16'h1400, Z);
    cyc("idle0", 1'b1, 1'b0, 16'h1400, Z);
    cyc("idle1", 1'b1, 1'b0, 16'h2300, Z);
    cyc("mvi_t0", 1'b1, 1'b1, 16'h1400, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("mvi_t1", 1'b1, 1'b0, 16'h00A5, v(0, 8'h00, 8'h04, 1, 0, 0, 0, 3'd0, 1, 0));
    cyc("mvi_back", 1'b1, 1'b0, 16'h00A5, Z);
    cyc("add_t0", 1'b1, 1'b1, 16'h2300, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("add_t1", 1'b1, 1'b0, 16'h0000, v(0, 8'h02, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0));
    cyc("add_t2", 1'b1, 1'b1, 16'h0000, v(0, 8'h10, 8'h00, 0, 0, 0, 1, 3'd0, 0, 0));
    cyc("add_t3", 1'b1, 1'b1, 16'h0000, v(0, 8'h00, 8'h02, 0, 1, 0, 0, 3'd0, 1, 0));
    cyc("srl_t0", 1'b1, 1'b1, 16'h71C0, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("srl_t1", 1'b1, 1'b1, 16'h3B80, v(0, 8'h01, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0));
    cyc("srl_t2", 1'b1, 1'b1, 16'h3B80, v(0, 8'h80, 8'h00, 0, 0, 0, 1, 3'd5, 0, 0));
    cyc("srl_t3", 1'b1, 1'b1, 16'h3B80, v(0, 8'h00, 8'h01, 0, 1, 0, 0, 3'd0, 1, 0));
    cyc("sub_t0", 1'b1, 1'b1, 16'h3B80, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("sub_t1", 1'b1, 1'b0, 16'h0CC0, v(0, 8'h20, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0));
    cyc("sub_t2", 1'b1, 1'b0, 16'h0CC0, v(0, 8'h40, 8'h00, 0, 0, 0, 1, 3'd1, 0, 0));
    cyc("sub_t3", 1'b1, 1'b1, 16'h0CC0, v(0, 8'h00, 8'h20, 0, 1, 0, 0, 3'd0, 1, 0));
    cyc("mv_t0", 1'b1, 1'b1, 16'h0CC0, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("mv_t1", 1'b1, 1'b0, 16'hFFFF, v(0, 8'h08, 8'h40, 0, 0, 0, 0, 3'd0, 1, 0));
    cyc("ill_t0", 1'b1, 1'b1, 16'hF000, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("ill_t1", 1'b1, 1'b0, 16'h0000, v(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 1));
    cyc("ill_after", 1'b1, 1'b0, 16'h0000, Z);
    cyc("slt_t0", 1'b1, 1'b1, 16'h54C0, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("slt_t1", 1'b1, 1'b0, 16'h0000, v(0, 8'h04, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0));
    cyc("slt_t2_rst", 1'b0, 1'b1, 16'h0000, Z);
    cyc("post_rst_t0", 1'b1, 1'b0, 16'h0000, Z);
    cyc("post_rst_idle", 1'b1, 1'b0, 16'h0000, Z);
    cyc("add2_t0", 1'b1, 1'b1, 16'h2300, v(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc("add2_t1", 1'b1, 1'b0, 16'h0000, v(0, 8'h02, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0));
    cyc("add2_t2", 1'b1, 1'b0, 16'h0000, v(0, 8'h10, 8'h00, 0, 0, 0, 1, 3'd0, 0, 0));
    cyc("add2_t3", 1'b1, 1'b0, 16'h0000, v(0, 8'h00, 8'h02, 0, 1, 0, 0, 3'd0, 1, 0));
    cyc("final_idle", 1'b1, 1'b0, 16'h0000, Z);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
